// File: rtl/free_list_controller.sv
`default_nettype none
// ============================================================================
// Module      : free_list_controller
// Description : Round-robin funnel of checker-lane free-list / no-redundancy
//               entries into one shared show-ahead queue, with kind counters.
// Revision    : 1.0 - initial release
// ============================================================================
module free_list_controller #(
    parameter int ITER_WIDTH = 9,
    parameter int NUM_LANES  = 4,
    parameter int Q_DEPTH    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clear,
    input  logic [NUM_LANES-1:0]            req_valid,
    input  logic [NUM_LANES-1:0]            req_kind,
    input  logic [NUM_LANES*ITER_WIDTH-1:0] req_iter,
    output logic [NUM_LANES-1:0]            req_ack,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ITER_WIDTH-1:0]           out_iter,
    output logic                            out_kind,
    output logic                            q_full,
    output logic                            q_empty,
    output logic [CNT_WIDTH-1:0]            fl_count,
    output logic [CNT_WIDTH-1:0]            nr_count
);

    localparam int                  c_PTR_W     = $clog2(Q_DEPTH);
    localparam int                  c_LANE_W    = $clog2(NUM_LANES);
    localparam logic [c_PTR_W:0]    c_FULL_OCC  = (c_PTR_W+1)'(Q_DEPTH);
    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(NUM_LANES-1);

    logic [ITER_WIDTH-1:0] w_lane_iter [NUM_LANES];
    logic [c_LANE_W-1:0]   w_grant_lane;
    logic                  w_found;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_push_kind;

    logic [c_LANE_W-1:0]   r_rr;
    logic [ITER_WIDTH:0]   r_mem [Q_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_occ;
    logic [CNT_WIDTH-1:0]  r_fl_cnt;
    logic [CNT_WIDTH-1:0]  r_nr_cnt;

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            assign w_lane_iter[g] = req_iter[g*ITER_WIDTH +: ITER_WIDTH];
        end
    endgenerate

    // First requesting lane at or after r_rr, searching modulo NUM_LANES.
    always_comb begin
        int idx;
        idx          = 0;
        w_found      = 1'b0;
        w_grant_lane = r_rr;
        for (int j = 0; j < NUM_LANES; j++) begin
            idx = int'(r_rr) + j;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            if (!w_found && req_valid[idx]) begin
                w_found      = 1'b1;
                w_grant_lane = c_LANE_W'(idx);
            end
        end
    end

    // A same-cycle pop never makes room: grants look at registered occupancy only.
    assign w_push      = w_found && !clear && (r_occ != c_FULL_OCC);
    assign w_pop       = (r_occ != '0) && out_ready;
    assign w_push_kind = req_kind[w_grant_lane];
    assign req_ack     = w_push ? (NUM_LANES'(1) << w_grant_lane) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr     <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_fl_cnt <= '0;
            r_nr_cnt <= '0;
            for (int i = 0; i < Q_DEPTH; i++) r_mem[i] <= '0;
        end else if (clear) begin
            r_rr     <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_fl_cnt <= '0;
            r_nr_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_push_kind, w_lane_iter[w_grant_lane]};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                r_rr            <= (w_grant_lane == c_LAST_LANE) ? '0 : w_grant_lane + 1'b1;
                if (w_push_kind) begin
                    if (r_nr_cnt != '1) r_nr_cnt <= r_nr_cnt + 1'b1;
                end else begin
                    if (r_fl_cnt != '1) r_fl_cnt <= r_fl_cnt + 1'b1;
                end
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign out_valid = (r_occ != '0);
    assign q_empty   = (r_occ == '0);
    assign q_full    = (r_occ == c_FULL_OCC);
    assign out_kind  = r_mem[r_rd_ptr][ITER_WIDTH];
    assign out_iter  = r_mem[r_rd_ptr][ITER_WIDTH-1:0];
    assign fl_count  = r_fl_cnt;
    assign nr_count  = r_nr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_free_list_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_free_list_controller
// Description : Directed self-checking bench for free_list_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_free_list_controller;

    localparam int IW = 9;
    localparam int NL = 4;
    localparam int QD = 16;
    localparam int CW = 16;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          clear     = 1'b0;
    logic          out_ready = 1'b0;
    logic [NL-1:0] req_valid = '0;
    logic [NL-1:0] req_kind  = '0;
    logic [NL*IW-1:0] req_iter = '0;

    logic [NL-1:0] req_ack;
    logic          out_valid, out_kind, q_full, q_empty;
    logic [IW-1:0] out_iter;
    logic [CW-1:0] fl_count, nr_count;

    logic [NL-1:0] s_req_ack;
    logic          s_out_valid, s_out_kind, s_q_full, s_q_empty;
    logic [IW-1:0] s_out_iter;
    logic [3:0]    s_fl_count, s_nr_count;

    int n_checks = 0;
    int n_errors = 0;
    logic [IW:0] sb [$];
    logic [IW:0] exp_e;

    free_list_controller #(.ITER_WIDTH(IW), .NUM_LANES(NL), .Q_DEPTH(QD), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .req_valid(req_valid), .req_kind(req_kind), .req_iter(req_iter), .req_ack(req_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_iter(out_iter), .out_kind(out_kind),
        .q_full(q_full), .q_empty(q_empty), .fl_count(fl_count), .nr_count(nr_count)
    );

    // Narrow-counter copy sharing the same stimulus, used for saturation.
    free_list_controller #(.ITER_WIDTH(IW), .NUM_LANES(NL), .Q_DEPTH(QD), .CNT_WIDTH(4)) u_dut_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .req_valid(req_valid), .req_kind(req_kind), .req_iter(req_iter), .req_ack(s_req_ack),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_iter(s_out_iter), .out_kind(s_out_kind),
        .q_full(s_q_full), .q_empty(s_q_empty), .fl_count(s_fl_count), .nr_count(s_nr_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_iter(input int lane, input logic [IW-1:0] v);
        req_iter[lane*IW +: IW] = v;
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_q_empty",   32'(q_empty),   32'd1);
        chk("rst_q_full",    32'(q_full),    32'd0);
        chk("rst_fl",        32'(fl_count),  32'd0);
        chk("rst_nr",        32'(nr_count),  32'd0);
        chk("rst_ack",       32'(req_ack),   32'd0);
        chk("rst_out_iter",  32'(out_iter),  32'd0);
        chk("rst_out_kind",  32'(out_kind),  32'd0);
        reset_n = 1'b1;
        tick();

        // Single request from lane 2
        req_valid = 4'b0100; req_kind = 4'b0000; set_iter(2, 9'h05A);
        #1;
        chk("single_ack", 32'(req_ack), 32'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_iter",  32'(out_iter),  32'h05A);
        chk("single_kind",  32'(out_kind),  32'd0);
        chk("single_fl",    32'(fl_count),  32'd1);
        chk("single_nr",    32'(nr_count),  32'd0);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        #1;
        chk("single_drained", 32'(q_empty), 32'd1);

        // Round-robin with all lanes holding requests
        for (int i = 0; i < NL; i++) set_iter(i, 9'(32'h100 + i));
        req_kind = 4'b1010; req_valid = 4'b1111; out_ready = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            chk("rr_ack", 32'(req_ack), 32'(1 << (c % 4)));
            if (c > 0) begin
                chk("rr_head_iter", 32'(out_iter), 32'(32'h100 + (c - 1) % 4));
                chk("rr_head_kind", 32'(out_kind), 32'((c - 1) % 2));
            end
            tick();
        end
        req_valid = '0;
        #1;
        chk("rr_fl", 32'(fl_count), 32'd4);
        chk("rr_nr", 32'(nr_count), 32'd4);
        tick();
        out_ready = 1'b0;
        #1;
        chk("rr_empty", 32'(q_empty), 32'd1);

        // Full queue
        clear = 1'b1; tick(); clear = 1'b0;
        req_valid = 4'b1111;
        #1;
        for (int c = 0; c < QD; c++) begin
            chk("full_fill_ack", 32'(req_ack), 32'(1 << (c % 4)));
            tick();
        end
        chk("full_flag", 32'(q_full),  32'd1);
        chk("full_ack0", 32'(req_ack), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("full_pop_ack", 32'(req_ack), 32'd0);
        tick();
        out_ready = 1'b0;
        #1;
        chk("full_after_pop", 32'(q_full),   32'd0);
        chk("full_head",      32'(out_iter), 32'h101);
        chk("full_regrant",   32'(req_ack),  32'b0001);
        tick();
        req_valid = '0;
        #1;
        chk("full_again", 32'(q_full),   32'd1);
        chk("full_fl",    32'(fl_count), 32'd9);
        chk("full_nr",    32'(nr_count), 32'd8);
        out_ready = 1'b1;
        for (int k = 0; k < QD; k++) begin
            chk("full_drain", 32'(out_iter), 32'(32'h100 + (k + 1) % 4));
            tick();
        end
        out_ready = 1'b0;
        #1;
        chk("full_drained", 32'(q_empty), 32'd1);

        // Wrap-around: 40 entries through lane 1
        clear = 1'b1; tick(); clear = 1'b0;
        sb.delete();
        for (int i = 0; i < 40; i++) begin
            req_valid   = 4'b0010;
            req_kind    = '0;
            req_kind[1] = (i % 3 == 0);
            set_iter(1, 9'(32'h20 + i));
            out_ready   = (i >= 8);
            #1;
            chk("wrap_ack", 32'(req_ack), 32'b0010);
            if (out_ready) begin
                exp_e = sb.pop_front();
                chk("wrap_iter", 32'(out_iter), 32'(exp_e[IW-1:0]));
                chk("wrap_kind", 32'(out_kind), 32'(exp_e[IW]));
            end
            sb.push_back({req_kind[1], 9'(32'h20 + i)});
            tick();
        end
        req_valid = '0; out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (sb.size() == 0) break;
            exp_e = sb.pop_front();
            chk("wrap_drain_iter", 32'(out_iter), 32'(exp_e[IW-1:0]));
            chk("wrap_drain_kind", 32'(out_kind), 32'(exp_e[IW]));
            tick();
        end
        out_ready = 1'b0;
        #1;
        chk("wrap_empty", 32'(q_empty),  32'd1);
        chk("wrap_fl",    32'(fl_count), 32'd26);
        chk("wrap_nr",    32'(nr_count), 32'd14);

        // Saturation of the narrow counter
        clear = 1'b1; tick(); clear = 1'b0;
        req_valid = 4'b1000; req_kind = 4'b1000; out_ready = 1'b1;
        #1;
        repeat (20) tick();
        req_valid = '0;
        #1;
        chk("sat_nr4",  32'(s_nr_count), 32'd15);
        chk("sat_fl4",  32'(s_fl_count), 32'd0);
        chk("sat_nr16", 32'(nr_count),   32'd20);
        tick();
        out_ready = 1'b0;

        // Clear with a pending request and 5 queued entries
        clear = 1'b1; tick(); clear = 1'b0;
        req_kind = 4'b1010; set_iter(0, 9'h0AA); set_iter(1, 9'h011); set_iter(2, 9'h022);
        req_valid = 4'b0110;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("clr_fill_ack", 32'(req_ack), (c % 2 == 0) ? 32'b0010 : 32'b0100);
            tick();
        end
        req_valid = 4'b0101; clear = 1'b1;
        #1;
        chk("clr_ack",     32'(req_ack),  32'd0);
        chk("clr_pre_occ", 32'(q_empty),  32'd0);
        chk("clr_pre_fl",  32'(fl_count), 32'd2);
        chk("clr_pre_nr",  32'(nr_count), 32'd3);
        tick();
        clear = 1'b0;
        #1;
        chk("clr_empty",  32'(q_empty),  32'd1);
        chk("clr_fl",     32'(fl_count), 32'd0);
        chk("clr_nr",     32'(nr_count), 32'd0);
        chk("clr_rr_ack", 32'(req_ack),  32'b0001);
        tick();
        req_valid = '0;
        #1;
        chk("clr_head_valid", 32'(out_valid), 32'd1);
        chk("clr_head_iter",  32'(out_iter),  32'h0AA);
        chk("clr_head_fl",    32'(fl_count),  32'd1);

        // Asynchronous reset between clock edges
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_empty", 32'(q_empty),   32'd1);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_fl",    32'(fl_count),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
